regfile_wr_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline writeback (WB)
//  and the long-latency unit (LU: mul/div) result stream. LU results are held in a small FIFO.
//  A 32-entry scoreboard flags registers with an LU write outstanding, for hazard stalls.
//  A starvation counter stalls WB so buffered LU results always retire.

---
 rtl/regfile_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: WB vs. buffered long-latency results, with a
// busy scoreboard and WB starvation stall. Optional same-cycle LU bypass: RF_ARB_BYPASS_EN.
module regfile_wr_arbiter #(
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_wd,
    output logic        wb_stall,
    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_wd,
    output logic        lu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wd
);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);
    localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] wd;
    } entry_t;

    entry_t          mem [BUF_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;
    logic [31:0]     busy, busy_nx;
    logic            empty, full, head_sel, byp, push, pop;
    entry_t          head;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign lu_ready = !full;
    assign head     = mem[rd_ptr];

    // FIFO head wins when WB is idle or has starved the FIFO long enough.
    assign head_sel = !empty && ((starve_cnt == SMAX) || !wb_we);
    assign wb_stall = wb_we && head_sel;
    assign pop      = head_sel;

`ifdef RF_ARB_BYPASS_EN
    assign byp = empty && !wb_we && lu_valid;
`else
    assign byp = 1'b0;
`endif

    assign push = lu_valid && lu_ready && !byp;

    always_comb begin
        rf_addr = wb_addr;
        rf_wd   = wb_wd;
        if (head_sel) begin
            rf_addr = head.addr;
            rf_wd   = head.wd;
        end else if (byp) begin
            rf_addr = lu_addr;
            rf_wd   = lu_wd;
        end
        // r0 writes are swallowed; a FIFO pop still happens.
        rf_we = (head_sel || wb_we || byp) && (rf_addr != 5'd0);
    end

    // Issue set is applied after the commit clear so a same-register race keeps busy.
    always_comb begin
        busy_nx = busy;
        if (pop || byp)
            busy_nx[rf_addr] = 1'b0;
        if (issue_valid)
            busy_nx[issue_addr] = 1'b1;
        busy_nx[0] = 1'b0;
    end

    assign rs_busy = busy[rs_addr];
    assign rt_busy = busy[rt_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy       <= '0;
        end else begin
            busy <= busy_nx;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (pop || empty)
                starve_cnt <= '0;
            else if (wb_we && (starve_cnt != SMAX))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{addr: lu_addr, wd: lu_wd};
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (default build, BUF_DEPTH=2, STARVE_MAX=4).
module tb_regfile_wr_arbiter;
    logic        clk, rst_n;
    logic        wb_we, wb_stall, lu_valid, lu_ready, issue_valid;
    logic        rs_busy, rt_busy, rf_we;
    logic [4:0]  wb_addr, lu_addr, issue_addr, rs_addr, rt_addr, rf_addr;
    logic [31:0] wb_wd, lu_wd, rf_wd;

    int errors = 0;
    int checks = 0;

    regfile_wr_arbiter #(.BUF_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_wd(wb_wd), .wb_stall(wb_stall),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_wd(lu_wd), .lu_ready(lu_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wbwe; logic [4:0] wa; logic [31:0] wd;
        logic        luv;  logic [4:0] la; logic [31:0] ld;
        logic        iv;   logic [4:0] ia;
        logic [4:0]  rs;   logic [4:0] rt;
        logic        e_we; logic [4:0] e_addr; logic [31:0] e_wd;
        logic        e_stall, e_ready, e_rsb, e_rtb;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic lv, input logic [4:0] la, input logic [31:0] ld,
                          input logic iv, input logic [4:0] ia,
                          input logic [4:0] rs, input logic [4:0] rt);
        wb_we = we; wb_addr = wa; wb_wd = wd;
        lu_valid = lv; lu_addr = la; lu_wd = ld;
        issue_valid = iv; issue_addr = ia;
        rs_addr = rs; rt_addr = rt;
    endtask

    initial begin
        logic        lv, stall_e, ready_e;
        logic [4:0]  la, addr_e;
        logic [31:0] ld, wd_e;

        //        wbwe wa     wd          luv la     ld          iv  ia     rs     rt     we  addr   wd          stl rdy rsb rtb
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,     0, 1, 0, 0});
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     1, 5'd7, 5'd7, 5'd0, 0, 5'd0, 32'h0,     0, 1, 0, 0});
        vt.push_back('{0, 5'd0, 32'h0,     1, 5'd7, 32'h1234,  0, 5'd0, 5'd7, 5'd0, 0, 5'd0, 32'h0,     0, 1, 1, 0});
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     0, 5'd0, 5'd7, 5'd0, 1, 5'd7, 32'h1234,  0, 1, 1, 0});
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     0, 5'd0, 5'd7, 5'd0, 0, 5'd0, 32'h0,     0, 1, 0, 0});
        vt.push_back('{1, 5'd4, 32'hAAAA,  0, 5'd0, 32'h0,     0, 5'd0, 5'd0, 5'd0, 1, 5'd4, 32'hAAAA,  0, 1, 0, 0});
        vt.push_back('{1, 5'd0, 32'hFFFF,  0, 5'd0, 32'h0,     1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,     0, 1, 0, 0});
        vt.push_back('{0, 5'd0, 32'h0,     1, 5'd0, 32'h55,    0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,     0, 1, 0, 0});
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,     0, 1, 0, 0});
        vt.push_back('{0, 5'd0, 32'h0,     1, 5'd2, 32'h22,    0, 5'd0, 5'd2, 5'd0, 0, 5'd0, 32'h0,     0, 1, 0, 0});
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     0, 5'd0, 5'd2, 5'd0, 1, 5'd2, 32'h22,    0, 1, 0, 0});
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     1, 5'd9, 5'd0, 5'd9, 0, 5'd0, 32'h0,     0, 1, 0, 0});
        vt.push_back('{0, 5'd0, 32'h0,     1, 5'd9, 32'h99,    0, 5'd0, 5'd0, 5'd9, 0, 5'd0, 32'h0,     0, 1, 0, 1});
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     1, 5'd9, 5'd0, 5'd9, 1, 5'd9, 32'h99,    0, 1, 0, 1});
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     0, 5'd0, 5'd7, 5'd9, 0, 5'd0, 32'h0,     0, 1, 0, 1});
        vt.push_back('{0, 5'd0, 32'h0,     1, 5'd9, 32'h98,    0, 5'd0, 5'd0, 5'd9, 0, 5'd0, 32'h0,     0, 1, 0, 1});
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     0, 5'd0, 5'd0, 5'd9, 1, 5'd9, 32'h98,    0, 1, 0, 1});
        vt.push_back('{0, 5'd0, 32'h0,     0, 5'd0, 32'h0,     0, 5'd0, 5'd0, 5'd9, 0, 5'd0, 32'h0,     0, 1, 0, 0});

        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset.rf_we", 32'(rf_we), 32'd0);
        chk("reset.wb_stall", 32'(wb_stall), 32'd0);
        chk("reset.lu_ready", 32'(lu_ready), 32'd1);
        chk("reset.rs_busy", 32'(rs_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk);
            set_in(vt[i].wbwe, vt[i].wa, vt[i].wd, vt[i].luv, vt[i].la, vt[i].ld,
                   vt[i].iv, vt[i].ia, vt[i].rs, vt[i].rt);
            #1;
            chk($sformatf("vec%0d.rf_we", i), 32'(rf_we), 32'(vt[i].e_we));
            if (vt[i].e_we) begin
                chk($sformatf("vec%0d.rf_addr", i), 32'(rf_addr), 32'(vt[i].e_addr));
                chk($sformatf("vec%0d.rf_wd", i), rf_wd, vt[i].e_wd);
            end
            chk($sformatf("vec%0d.wb_stall", i), 32'(wb_stall), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d.lu_ready", i), 32'(lu_ready), 32'(vt[i].e_ready));
            chk($sformatf("vec%0d.rs_busy", i), 32'(rs_busy), 32'(vt[i].e_rsb));
            chk($sformatf("vec%0d.rt_busy", i), 32'(rt_busy), 32'(vt[i].e_rtb));
        end

        // Starvation + full FIFO: WB writes r10 every cycle; LU offers A(r3), B(r12),
        // then C(r13) held until accepted the cycle after A retires.
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            lv = 1'b0; la = 5'd0; ld = 32'h0;
            if (c == 0) begin lv = 1'b1; la = 5'd3;  ld = 32'h333; end
            else if (c == 1) begin lv = 1'b1; la = 5'd12; ld = 32'hC12; end
            else if (c >= 2 && c <= 6) begin lv = 1'b1; la = 5'd13; ld = 32'hD13; end
            set_in(1, 5'd10, 32'hB0, lv, la, ld, 0, 0, 0, 0);
            #1;
            stall_e = (c == 5) || (c == 10) || (c == 15);
            ready_e = !((c >= 2 && c <= 5) || (c >= 7 && c <= 10));
            addr_e  = (c == 5) ? 5'd3 : (c == 10) ? 5'd12 : (c == 15) ? 5'd13 : 5'd10;
            wd_e    = (c == 5) ? 32'h333 : (c == 10) ? 32'hC12 : (c == 15) ? 32'hD13 : 32'hB0;
            chk($sformatf("starve%0d.wb_stall", c), 32'(wb_stall), 32'(stall_e));
            chk($sformatf("starve%0d.lu_ready", c), 32'(lu_ready), 32'(ready_e));
            chk($sformatf("starve%0d.rf_we", c), 32'(rf_we), 32'd1);
            chk($sformatf("starve%0d.rf_addr", c), 32'(rf_addr), 32'(addr_e));
            chk($sformatf("starve%0d.rf_wd", c), rf_wd, wd_e);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("drained.rf_we", 32'(rf_we), 32'd0);

        // Reset mid-operation: two entries buffered, busy[5] set.
        @(negedge clk);
        set_in(1, 5'd10, 32'hB0, 1, 5'd5, 32'h1, 1, 5'd5, 5'd5, 5'd0);
        @(negedge clk);
        set_in(1, 5'd10, 32'hB0, 1, 5'd6, 32'h2, 0, 0, 5'd5, 5'd0);
        #1;
        chk("t1.pre_busy5", 32'(rs_busy), 32'd1);
        @(negedge clk);
        set_in(1, 5'd10, 32'hB0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        #1;
        chk("t1.full", 32'(lu_ready), 32'd0);
        #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        rst_n = 1'b0;
        #1;
        chk("t1.rf_we", 32'(rf_we), 32'd0);
        chk("t1.lu_ready", 32'(lu_ready), 32'd1);
        chk("t1.busy5", 32'(rs_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("t1.post_rf_we", 32'(rf_we), 32'd0);
        chk("t1.post_lu_ready", 32'(lu_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
